// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: signal bundle between the multicycle controller and the datapath/memory
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       retire;
  logic       illegal;
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, result_src, imm_src, retire, illegal
  );
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, result_src, imm_src, retire, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the RV32I-subset core
module multicycle_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master ctrl
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  state_t     state_q, state_d;
  logic       f3_ok;
  logic       op_ok;
  logic [2:0] alu_dec;
  // ALU operation and legality decoded from funct3; sub only for R-type with funct7b5
  always_comb begin
    f3_ok   = (ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b111) ||
              (ctrl.funct3 == 3'b110) || (ctrl.funct3 == 3'b010);
    alu_dec = ctrl.funct3 == 3'b000 ? ((state_q == S_EXECR && ctrl.funct7b5) ? 3'b001 : 3'b000) :
              ctrl.funct3 == 3'b111 ? 3'b010 :
              ctrl.funct3 == 3'b110 ? 3'b011 :
              ctrl.funct3 == 3'b010 ? 3'b101 : 3'b000;
    op_ok   = (ctrl.op == OP_LW) || (ctrl.op == OP_SW) || (ctrl.op == OP_R) ||
              (ctrl.op == OP_I) || (ctrl.op == OP_BR && ctrl.funct3[2:1] == 2'b00);
  end
  // next state and datapath controls, decoded from the registered state
  always_comb begin
    state_d          = state_q;
    ctrl.mem_req     = 1'b0;
    ctrl.mem_write   = 1'b0;
    ctrl.adr_src     = 1'b0;
    ctrl.ir_write    = 1'b0;
    ctrl.pc_write    = 1'b0;
    ctrl.reg_write   = 1'b0;
    ctrl.alu_src_a   = 2'b00;
    ctrl.alu_src_b   = 2'b00;
    ctrl.alu_control = 3'b000;
    ctrl.result_src  = 2'b00;
    ctrl.imm_src     = 2'b00;
    ctrl.retire      = 1'b0;
    ctrl.illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.ir_write   = ctrl.mem_ready;
        ctrl.pc_write   = ctrl.mem_ready;
        state_d         = ctrl.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        ctrl.imm_src   = 2'b10;
        ctrl.illegal   = !op_ok;
        state_d = !op_ok                                   ? S_FETCH  :
                  (ctrl.op == OP_LW || ctrl.op == OP_SW)   ? S_MEMADR :
                  ctrl.op == OP_R                          ? S_EXECR  :
                  ctrl.op == OP_I                          ? S_EXECI  : S_BRANCH;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.imm_src   = ctrl.op == OP_SW ? 2'b01 : 2'b00;
        state_d        = ctrl.op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        state_d      = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.retire    = ctrl.mem_ready;
        state_d        = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = state_q == S_EXECI ? 2'b01 : 2'b00;
        ctrl.alu_control = alu_dec;
        ctrl.illegal     = !f3_ok;
        state_d          = f3_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = 3'b001;
        ctrl.pc_write    = ctrl.funct3[0] ? !ctrl.zero : ctrl.zero;
        ctrl.retire      = 1'b1;
        state_d          = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state register; reset abandons any in-flight access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench comparing per-cycle control vectors against an instruction model
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .ctrl(bus));
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011, BR = 7'b1100011;
  logic [18:0] act;
  logic [18:0] exp_q[$];
  logic [18:0] act_q[$];
  int n_cmp = 0;
  int n_err = 0;
  assign act = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src, bus.imm_src,
                bus.retire, bus.illegal};
  function automatic logic [18:0] ev(input logic rq, wr, adr, irw, pcw, rgw, input logic [1:0] a, b,
                                     input logic [2:0] alu, input logic [1:0] res, imm, input logic ret, ill);
    return {rq, wr, adr, irw, pcw, rgw, a, b, alu, res, imm, ret, ill};
  endfunction
  // one clock cycle: drive, record expected, sample mid-cycle
  task automatic cyc(input logic rdy, input logic [18:0] e);
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    act_q.push_back(act);
    @(posedge clk);
    #1;
  endtask
  // reference model of one instruction's cycle-by-cycle controls
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, input int fs, ms);
    logic ok, bad;
    logic [2:0] alu;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    for (int i = 0; i < fs; i++) cyc(1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,2'b00,0,0));
    cyc(1'b1, ev(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b10,2'b00,0,0));
    ok = op == LW || op == SW || op == RT || op == IT || (op == BR && (f3 == 3'b000 || f3 == 3'b001));
    cyc(1'b0, ev(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,2'b10,0,!ok));
    if (!ok) return;
    if (op == LW) begin
      cyc(1'b0, ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b00,0,0));
      for (int i = 0; i < ms; i++) cyc(1'b0, ev(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
      cyc(1'b1, ev(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
      cyc(1'b0, ev(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b01,2'b00,1,0));
    end else if (op == SW) begin
      cyc(1'b0, ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b01,0,0));
      for (int i = 0; i < ms; i++) cyc(1'b0, ev(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
      cyc(1'b1, ev(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,1,0));
    end else if (op == BR) begin
      cyc(1'b0, ev(0,0,0,0,f3 == 3'b000 ? z : !z,0,2'b10,2'b00,3'b001,2'b00,2'b00,1,0));
    end else begin
      bad = 1'b0;
      case (f3)
        3'b000:  alu = (op == RT && f7) ? 3'b001 : 3'b000;
        3'b111:  alu = 3'b010;
        3'b110:  alu = 3'b011;
        3'b010:  alu = 3'b101;
        default: begin alu = 3'b000; bad = 1'b1; end
      endcase
      cyc(1'b0, ev(0,0,0,0,0,0,2'b10,op == IT ? 2'b01 : 2'b00,alu,2'b00,2'b00,0,bad));
      if (!bad) cyc(1'b0, ev(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,1,0));
    end
  endtask
  task automatic test_reset;
    bus.mem_ready = 1'b1; bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act !== 19'd0) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", act, 19'd0); end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (act !== 19'd0) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", act, 19'd0); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (act !== ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,2'b00,0,0)) begin
      n_err++; $display("FAIL reset_first_fetch got=%h", act);
    end
  endtask
  task automatic test_lw_stall;
    int k = 0;
    run(LW, 3'b010, 1'b0, 1'b0, 2, 2);
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_sw;
    int k = 0;
    run(SW, 3'b010, 1'b0, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL sw cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_branch;
    int k = 0;
    run(BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run(BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run(BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run(BR, 3'b001, 1'b0, 1'b1, 0, 0);
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL branch cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_alu;
    int k = 0;
    run(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run(RT, 3'b010, 1'b0, 1'b0, 0, 0);
    run(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    run(RT, 3'b111, 1'b0, 1'b0, 0, 0);
    run(IT, 3'b110, 1'b0, 1'b0, 0, 0);
    run(IT, 3'b010, 1'b0, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL alu cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_illegal;
    int k = 0;
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    run(RT, 3'b001, 1'b0, 1'b0, 0, 0);
    run(BR, 3'b100, 1'b0, 1'b1, 0, 0);
    run(IT, 3'b101, 1'b0, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL illegal cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_back_to_back;
    logic [6:0] ops [8] = '{LW, SW, RT, IT, BR, LW, BR, SW};
    logic [2:0] f3s [8] = '{3'b010, 3'b010, 3'b110, 3'b111, 3'b001, 3'b010, 3'b000, 3'b010};
    int k = 0;
    for (int i = 0; i < 8; i++)
      run(ops[i], f3s[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL b2b cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  task automatic test_reset_mid;
    int k = 0;
    bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    cyc(1'b1, ev(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b10,2'b00,0,0));
    cyc(1'b0, ev(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,2'b10,0,0));
    cyc(1'b0, ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b00,0,0));
    cyc(1'b0, ev(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", k, a, e); end
    end
    #2;
    n_cmp++;
    if (act !== ev(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0)) begin
      n_err++; $display("FAIL rst_mid_memread got=%h", act);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (act !== 19'd0) begin n_err++; $display("FAIL rst_mid_async got=%h exp=%h", act, 19'd0); end
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (act !== 19'd0) begin n_err++; $display("FAIL rst_mid_held got=%h exp=%h", act, 19'd0); end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (act !== 19'd0) begin n_err++; $display("FAIL rst_mid_idle got=%h exp=%h", act, 19'd0); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (act !== ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,2'b00,0,0)) begin
      n_err++; $display("FAIL rst_mid_fetch got=%h", act);
    end
    run(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    k = 0;
    while (exp_q.size() != 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); n_cmp++; k++;
      if (a !== e) begin n_err++; $display("FAIL rst_mid_after cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask
  initial begin
    test_reset;
    test_lw_stall;
    test_sw;
    test_branch;
    test_alu;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
